// File: rtl/move_input_conditioner.sv
// Turns four raw push-buttons into debounced, single-shot move commands
// delivered to the game logic under a valid/ready handshake.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] btn_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       s1, s2;
    logic [3:0]       stable, stable_q;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       press;
    logic             warm, armed;
    logic [1:0]       press_dir;
    state_t           state, state_nxt;
    logic [1:0]       dir, dir_nxt;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            // NOTE: the counter array is reset explicitly; reset must abort any debounce in progress.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_q <= stable;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_q;

    // Buttons held through reset re-debounce to 1; arm only after the
    // synchroniser has seen every button released, so that edge is not a move.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm  <= 1'b0;
            armed <= 1'b0;
        end else begin
            warm  <= 1'b1;
            armed <= armed | (warm & ~|s1 & ~|s2);
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        press_dir = 2'd3;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (armed && |press) begin
                    dir_nxt   = press_dir;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (move_ready) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (stable == 4'b0000) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            dir   <= 2'd0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
        end
    end

    assign move_valid = (state == PENDING);
    assign move_dir   = dir;
    assign btn_state  = stable;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES = 4; a
// scoreboard queue holds expected directions, popped on each handshake.
module tb_move_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] btn_state;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [1:0] exp_q [$];

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .btn_state (btn_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (move_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, {3'b000, move_valid}, 4'd1);
    endtask

    task automatic release_all();
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(12);
    endtask

    // Handshake monitor: valid & ready seen mid-cycle means acceptance at the next edge.
    always @(negedge clk) begin
        if (rst_n && move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_move", {2'b00, move_dir}, 4'hf);
            end else begin
                check("move_dir", {2'b00, move_dir}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        move_ready = 1'b1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        tick(3);
        check("rst_valid", {3'b000, move_valid}, 4'd0);
        check("rst_dir",   {2'b00, move_dir},    4'd0);
        check("rst_state", btn_state,            4'b0000);
        rst_n = 1'b1;
        tick(5);

        // Clean press: exact debounce and handshake latency.
        btn_left = 1'b1;
        exp_q.push_back(2'd2);
        tick(5);
        check("t1_state_e4", btn_state, 4'b0000);
        tick();
        check("t1_state_e5", btn_state, 4'b0100);
        check("t1_valid_e5", {3'b000, move_valid}, 4'd0);
        tick();
        check("t1_valid_e6", {3'b000, move_valid}, 4'd1);
        check("t1_dir_e6",   {2'b00, move_dir},    4'd2);
        tick();
        check("t1_valid_e7", {3'b000, move_valid}, 4'd0);
        tick(20);
        check("t1_held", {3'b000, move_valid}, 4'd0);
        release_all();
        check("t1_released", btn_state, 4'b0000);

        // Glitch rejection: 3 high, 1 low, repeated.
        for (int i = 0; i < 40; i++) begin
            btn_up = (i % 4) != 3;
            tick();
            check("t2_state", btn_state, 4'b0000);
            check("t2_valid", {3'b000, move_valid}, 4'd0);
        end
        release_all();

        // Priority: down beats right; then right alone.
        btn_right = 1'b1;
        btn_down  = 1'b1;
        exp_q.push_back(2'd1);
        tick(12);
        check("t3_state", btn_state, 4'b1010);
        check("t3_valid", {3'b000, move_valid}, 4'd0);
        release_all();
        btn_right = 1'b1;
        exp_q.push_back(2'd3);
        tick(12);
        release_all();

        // Backpressure with an extra press while pending.
        move_ready = 1'b0;
        btn_down   = 1'b1;
        exp_q.push_back(2'd1);
        wait_valid("t4_wait_valid");
        btn_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_hold_valid", {3'b000, move_valid}, 4'd1);
            check("t4_hold_dir",   {2'b00, move_dir},    4'd1);
        end
        check("t4_state", btn_state, 4'b0011);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        check("t4_accepted", {3'b000, move_valid}, 4'd0);
        tick(5);
        check("t4_no_second", {3'b000, move_valid}, 4'd0);
        move_ready = 1'b1;
        release_all();

        // Lockout: second button while holding the first yields nothing.
        btn_up = 1'b1;
        exp_q.push_back(2'd0);
        tick(12);
        btn_left = 1'b1;
        tick(12);
        check("t5_state", btn_state, 4'b0101);
        check("t5_valid", {3'b000, move_valid}, 4'd0);
        release_all();
        btn_left = 1'b1;
        exp_q.push_back(2'd2);
        tick(12);
        release_all();

        // Reset while pending discards the move; held button needs a re-press.
        move_ready = 1'b0;
        btn_right  = 1'b1;
        wait_valid("t6_wait_valid");
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", {3'b000, move_valid}, 4'd0);
        check("t6_rst_dir",   {2'b00, move_dir},    4'd0);
        check("t6_rst_state", btn_state,            4'b0000);
        rst_n      = 1'b1;
        move_ready = 1'b1;
        tick(20);
        check("t6_held_state", btn_state, 4'b1000);
        check("t6_held_valid", {3'b000, move_valid}, 4'd0);
        release_all();
        btn_right = 1'b1;
        exp_q.push_back(2'd3);
        tick(12);
        release_all();

        check("queue_empty", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
